// File: rtl/cl_stream_ctrl_regs_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cl_stream_ctrl_regs_if                                         |
// | Brief   : cfg_bus pulse/ack interface between OCL slave and reg block.   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface cl_stream_ctrl_regs_if;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_wr;
    logic        cfg_rd;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_addr,
        output cfg_wdata,
        output cfg_wr,
        output cfg_rd,
        input  cfg_ack,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_addr,
        input  cfg_wdata,
        input  cfg_wr,
        input  cfg_rd,
        output cfg_ack,
        output cfg_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cl_stream_ctrl_regs.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cl_stream_ctrl_regs                                            |
// | Brief   : cfg_bus register slave owning the streaming start/abort/timeout|
// |           FSM and its saturating cycle/beat counters.                    |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cl_stream_ctrl_regs #(
    parameter int unsigned CNT_W       = 32,
    parameter logic [31:0] TIMEOUT_RST = 32'h0,
    parameter logic [31:0] BAD_RDATA   = 32'hDEAD_BEEF
) (
    input  wire logic            clk,
    input  wire logic            sync_rst_n,
    cl_stream_ctrl_regs_if.slave cfg,
    input  wire logic            set_streaming_finished,
    input  wire logic            stream_beat,
    output logic                 streaming_active,
    output logic                 stream_start,
    output logic                 stream_abort
);

    localparam logic [5:0] c_IDX_CTRL    = 6'h00;
    localparam logic [5:0] c_IDX_STATUS  = 6'h01;
    localparam logic [5:0] c_IDX_CYCLE   = 6'h02;
    localparam logic [5:0] c_IDX_BEAT    = 6'h03;
    localparam logic [5:0] c_IDX_TIMEOUT = 6'h04;
    localparam logic [5:0] c_IDX_SCRATCH = 6'h05;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_req_wr;
    logic              r_req_rd;
    logic [5:0]        r_req_idx;
    logic [31:0]       r_req_wdata;

    logic              r_ack;
    logic [31:0]       r_rdata;
    logic              r_start_pls;
    logic              r_abort_pls;

    logic              r_done;
    logic              r_timeout_flg;
    logic              r_start_err;
    logic [31:0]       r_timeout;
    logic [31:0]       r_scratch;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic              w_req;
    logic              w_ctrl_wr;
    logic              w_status_wr;
    logic              w_start_wr;
    logic              w_abort_wr;
    logic              w_is_active;
    logic [31:0]       w_cycle_ext;
    logic [31:0]       w_beat_ext;
    logic [32:0]       w_cycle_nxt_ext;
    logic              w_to_hit;
    logic [CNT_W-1:0]  w_cycle_inc;
    logic [CNT_W-1:0]  w_beat_inc;
    logic [31:0]       w_rdata;

    logic              w_start_fire;
    logic              w_abort_fire;
    logic              w_done_set;
    logic              w_to_set;
    logic              w_err_set;

    logic              w_unused_addr;

    assign w_unused_addr = ^{cfg.cfg_addr[31:8], cfg.cfg_addr[1:0]};

    // Requests are captured at one edge and committed (ack, rdata, writes) at the next.
    assign w_req       = r_req_wr | r_req_rd;
    assign w_ctrl_wr   = r_req_wr && (r_req_idx == c_IDX_CTRL);
    assign w_status_wr = r_req_wr && (r_req_idx == c_IDX_STATUS);
    assign w_start_wr  = w_ctrl_wr && r_req_wdata[0];
    assign w_abort_wr  = w_ctrl_wr && r_req_wdata[1];
    assign w_is_active = (r_state == ST_ACTIVE);

    assign w_cycle_ext     = 32'(r_cycle_cnt);
    assign w_beat_ext      = 32'(r_beat_cnt);
    assign w_cycle_nxt_ext = {1'b0, w_cycle_ext} + 33'd1;
    assign w_to_hit        = (r_timeout != 32'd0) && (w_cycle_nxt_ext == {1'b0, r_timeout});

    assign w_cycle_inc = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1);
    assign w_beat_inc  = (&r_beat_cnt)  ? r_beat_cnt  : r_beat_cnt  + CNT_W'(1);

    always_comb begin
        w_rdata = BAD_RDATA;
        case (r_req_idx)
            c_IDX_CTRL:    w_rdata = {31'b0, w_is_active};
            c_IDX_STATUS:  w_rdata = {28'b0, r_start_err, r_timeout_flg, r_done, w_is_active};
            c_IDX_CYCLE:   w_rdata = w_cycle_ext;
            c_IDX_BEAT:    w_rdata = w_beat_ext;
            c_IDX_TIMEOUT: w_rdata = r_timeout;
            c_IDX_SCRATCH: w_rdata = r_scratch;
            default:       w_rdata = BAD_RDATA;
        endcase
    end

    // Exit priority in ACTIVE: finish > timeout > ABORT write.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_fire = 1'b0;
        w_abort_fire = 1'b0;
        w_done_set   = 1'b0;
        w_to_set     = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_wr && !w_abort_wr) begin
                    w_state_nxt  = ST_ACTIVE;
                    w_start_fire = 1'b1;
                end
            end
            ST_ACTIVE: begin
                w_err_set = w_start_wr;
                if (set_streaming_finished) begin
                    w_state_nxt = ST_IDLE;
                    w_done_set  = 1'b1;
                end else if (w_to_hit) begin
                    w_state_nxt  = ST_IDLE;
                    w_to_set     = 1'b1;
                    w_abort_fire = 1'b1;
                end else if (w_abort_wr) begin
                    w_state_nxt  = ST_IDLE;
                    w_abort_fire = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            r_req_wr      <= 1'b0;
            r_req_rd      <= 1'b0;
            r_req_idx     <= 6'h00;
            r_req_wdata   <= 32'h0;
            r_ack         <= 1'b0;
            r_rdata       <= 32'h0;
            r_start_pls   <= 1'b0;
            r_abort_pls   <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_flg <= 1'b0;
            r_start_err   <= 1'b0;
            r_timeout     <= TIMEOUT_RST;
            r_scratch     <= 32'h0;
            r_cycle_cnt   <= '0;
            r_beat_cnt    <= '0;
        end else begin
            r_req_wr    <= cfg.cfg_wr;
            r_req_rd    <= cfg.cfg_rd;
            r_req_idx   <= cfg.cfg_addr[7:2];
            r_req_wdata <= cfg.cfg_wdata;

            r_ack   <= w_req;
            r_rdata <= r_req_rd ? w_rdata : 32'h0;

            r_start_pls <= w_start_fire;
            r_abort_pls <= w_abort_fire;

            // A flag being set on the same edge as its W1C clear stays set.
            r_done        <= w_done_set | (r_done        & ~(w_status_wr & r_req_wdata[1]));
            r_timeout_flg <= w_to_set   | (r_timeout_flg & ~(w_status_wr & r_req_wdata[2]));
            r_start_err   <= w_err_set  | (r_start_err   & ~(w_status_wr & r_req_wdata[3]));

            if (r_req_wr && (r_req_idx == c_IDX_TIMEOUT)) begin
                r_timeout <= r_req_wdata;
            end
            if (r_req_wr && (r_req_idx == c_IDX_SCRATCH)) begin
                r_scratch <= r_req_wdata;
            end

            if (w_start_fire) begin
                r_cycle_cnt <= '0;
                r_beat_cnt  <= '0;
            end else if (w_is_active) begin
                r_cycle_cnt <= w_cycle_inc;
                if (stream_beat) begin
                    r_beat_cnt <= w_beat_inc;
                end
            end
        end
    end

    assign cfg.cfg_ack       = r_ack;
    assign cfg.cfg_rdata     = r_rdata;
    assign streaming_active  = w_is_active;
    assign stream_start      = r_start_pls;
    assign stream_abort      = r_abort_pls;

endmodule
`default_nettype wire

// File: tb/tb_cl_stream_ctrl_regs.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_cl_stream_ctrl_regs                                         |
// | Brief   : Directed self-checking bench for cl_stream_ctrl_regs.          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_cl_stream_ctrl_regs;

    logic clk;
    logic sync_rst_n;
    logic set_streaming_finished;
    logic stream_beat;
    logic streaming_active;
    logic stream_start;
    logic stream_abort;

    int   n_tests;
    int   n_fail;
    int   n_start;
    int   n_abort;

    cl_stream_ctrl_regs_if bus ();

    cl_stream_ctrl_regs #(
        .CNT_W       (32),
        .TIMEOUT_RST (32'h0),
        .BAD_RDATA   (32'hDEAD_BEEF)
    ) u_dut (
        .clk                    (clk),
        .sync_rst_n             (sync_rst_n),
        .cfg                    (bus),
        .set_streaming_finished (set_streaming_finished),
        .stream_beat            (stream_beat),
        .streaming_active       (streaming_active),
        .stream_start           (stream_start),
        .stream_abort           (stream_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses are registered, so each one spans exactly one negedge.
    initial begin
        n_start = 0;
        n_abort = 0;
    end
    always @(negedge clk) begin
        if (stream_start) n_start = n_start + 1;
        if (stream_abort) n_abort = n_abort + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Request sampled at edge N, ack/commit at N+1, idle again at N+2.
    task automatic bus_acc(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic fin,
                           output logic [31:0] rdata);
        @(negedge clk);
        bus.cfg_wr    = wr;
        bus.cfg_rd    = rd;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wdata;
        @(posedge clk); #1;
        check_val("ack_at_n", 32'(bus.cfg_ack), 32'd0);
        @(negedge clk);
        bus.cfg_wr = 1'b0;
        bus.cfg_rd = 1'b0;
        set_streaming_finished = fin;
        @(posedge clk); #1;
        check_val("ack_at_n1", 32'(bus.cfg_ack), 32'd1);
        rdata = bus.cfg_rdata;
        @(negedge clk);
        set_streaming_finished = 1'b0;
        @(posedge clk); #1;
        check_val("ack_at_n2", 32'(bus.cfg_ack), 32'd0);
        check_val("rdata_idle", bus.cfg_rdata, 32'd0);
    endtask

    task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        bus_acc(1'b1, 1'b0, addr, wdata, 1'b0, dummy);
    endtask

    task automatic reg_rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus_acc(1'b0, 1'b1, addr, 32'h0, 1'b0, rd);
        check_val(tag, rd, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_rst [6];
        logic [31:0] rd;
        int          ns0;
        int          na0;

        n_tests = 0;
        n_fail  = 0;
        exp_rst[0] = 32'h0;
        exp_rst[1] = 32'h0;
        exp_rst[2] = 32'h0;
        exp_rst[3] = 32'h0;
        exp_rst[4] = 32'h0;
        exp_rst[5] = 32'h0;

        sync_rst_n             = 1'b0;
        set_streaming_finished = 1'b0;
        stream_beat            = 1'b0;
        bus.cfg_wr             = 1'b0;
        bus.cfg_rd             = 1'b0;
        bus.cfg_addr           = 32'h0;
        bus.cfg_wdata          = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_active", 32'(streaming_active), 32'd0);
        check_val("rst_start",  32'(stream_start),     32'd0);
        check_val("rst_abort",  32'(stream_abort),     32'd0);
        check_val("rst_ack",    32'(bus.cfg_ack),      32'd0);
        check_val("rst_rdata",  bus.cfg_rdata,         32'd0);
        @(negedge clk);
        sync_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            reg_rd_chk("rst_reg", 32'(i * 4), exp_rst[i]);
        end
        reg_rd_chk("unmapped_rd", 32'h40, 32'hDEAD_BEEF);

        // Register read/write basics
        reg_wr(32'h14, 32'h1234_5678);
        reg_rd_chk("scratch", 32'h14, 32'h1234_5678);
        reg_rd_chk("scratch_alias", 32'h114, 32'h1234_5678);
        reg_wr(32'h08, 32'hFFFF_FFFF);
        reg_rd_chk("cycle_ro", 32'h08, 32'h0);
        bus_acc(1'b1, 1'b1, 32'h14, 32'hCAFE_F00D, 1'b0, rd);
        check_val("wr_rd_prewrite", rd, 32'h1234_5678);
        reg_rd_chk("scratch_new", 32'h14, 32'hCAFE_F00D);
        reg_wr(32'h40, 32'h1);
        reg_rd_chk("unmapped_wr_drop", 32'h14, 32'hCAFE_F00D);

        // START, 10 beats over 20 cycles, finish
        ns0 = n_start;
        na0 = n_abort;
        reg_wr(32'h00, 32'h1);
        check_val("t3_start_pls", 32'(n_start - ns0), 32'd1);
        check_val("t3_active", 32'(streaming_active), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            stream_beat = (i % 2 == 0);
        end
        @(negedge clk);
        stream_beat            = 1'b0;
        set_streaming_finished = 1'b1;
        @(negedge clk);
        set_streaming_finished = 1'b0;
        check_val("t3_idle", 32'(streaming_active), 32'd0);
        check_val("t3_no_abort", 32'(n_abort - na0), 32'd0);
        reg_rd_chk("t3_status", 32'h04, 32'h2);
        reg_rd_chk("t3_beat", 32'h0C, 32'd10);
        // Active edges: one in the write task tail, 20 beat-loop edges, the exit edge.
        reg_rd_chk("t3_cycle", 32'h08, 32'd22);
        reg_rd_chk("t3_ctrl", 32'h00, 32'h0);
        reg_wr(32'h04, 32'h2);
        reg_rd_chk("t3_status_clr", 32'h04, 32'h0);

        // Timeout after 5 active cycles
        reg_wr(32'h10, 32'd5);
        reg_rd_chk("t4_timeout_rd", 32'h10, 32'd5);
        na0 = n_abort;
        reg_wr(32'h00, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check_val("t4_active_c4", 32'(streaming_active), 32'd1);
        @(posedge clk); #1;
        check_val("t4_idle_c5", 32'(streaming_active), 32'd0);
        @(negedge clk); #1;
        check_val("t4_abort_pls", 32'(n_abort - na0), 32'd1);
        reg_rd_chk("t4_status", 32'h04, 32'h4);
        reg_rd_chk("t4_cycle", 32'h08, 32'd5);
        reg_rd_chk("t4_beat", 32'h0C, 32'd0);
        reg_wr(32'h04, 32'h4);
        reg_rd_chk("t4_status_clr", 32'h04, 32'h0);
        reg_wr(32'h10, 32'd0);

        // START while active, then finish and ABORT on the same edge
        ns0 = n_start;
        reg_wr(32'h00, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stream_beat = 1'b1;
        end
        @(negedge clk);
        stream_beat = 1'b0;
        reg_wr(32'h00, 32'h1);
        check_val("t5_one_start", 32'(n_start - ns0), 32'd1);
        reg_rd_chk("t5_status_err", 32'h04, 32'h9);
        reg_rd_chk("t5_beat_kept", 32'h0C, 32'd3);
        na0 = n_abort;
        bus_acc(1'b1, 1'b0, 32'h00, 32'h2, 1'b1, rd);
        @(negedge clk); #1;
        check_val("t5_idle", 32'(streaming_active), 32'd0);
        check_val("t5_no_abort", 32'(n_abort - na0), 32'd0);
        reg_rd_chk("t5_status_done", 32'h04, 32'hA);
        reg_wr(32'h04, 32'hE);
        reg_rd_chk("t5_status_clr", 32'h04, 32'h0);

        // START+ABORT from IDLE: nothing happens
        ns0 = n_start;
        na0 = n_abort;
        reg_wr(32'h00, 32'h3);
        @(negedge clk); #1;
        check_val("sa_idle", 32'(streaming_active), 32'd0);
        check_val("sa_no_start", 32'(n_start - ns0), 32'd0);
        check_val("sa_no_abort", 32'(n_abort - na0), 32'd0);

        // Plain ABORT exit
        reg_wr(32'h00, 32'h1);
        na0 = n_abort;
        reg_wr(32'h00, 32'h2);
        @(negedge clk); #1;
        check_val("ab_idle", 32'(streaming_active), 32'd0);
        check_val("ab_pls", 32'(n_abort - na0), 32'd1);
        reg_rd_chk("ab_status", 32'h04, 32'h0);

        // Reset while active with counters nonzero
        reg_wr(32'h10, 32'd1000);
        reg_wr(32'h00, 32'h1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            stream_beat = 1'b1;
        end
        @(negedge clk);
        stream_beat = 1'b0;
        reg_rd_chk("t6_beat_pre", 32'h0C, 32'd2);
        @(negedge clk); #2;
        ns0 = n_start;
        na0 = n_abort;
        sync_rst_n = 1'b0;
        #1;
        check_val("t6_active_now", 32'(streaming_active), 32'd0);
        check_val("t6_start_low",  32'(stream_start),     32'd0);
        check_val("t6_abort_low",  32'(stream_abort),     32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sync_rst_n = 1'b1;
        check_val("t6_no_start_pls", 32'(n_start - ns0), 32'd0);
        check_val("t6_no_abort_pls", 32'(n_abort - na0), 32'd0);
        for (int i = 0; i < 6; i++) begin
            reg_rd_chk("t6_reg", 32'(i * 4), exp_rst[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
